alu_muldiv: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle datapath ALU. It executes the existing ADD/SUB/LUI operations plus logic ops and the RISC-V M-extension multiply/divide/remainder family, with a start/valid handshake. Single-cycle ops return after one clock; multiply and divide use an iterative shift-add / restoring-divide engine, one bit per clock. It sits in the execute stage, and the control unit stalls the PC while `busy_o` is high.

---
 rtl/alu_muldiv.sv | 199 +++++++++++++++++++
 tb/tb_alu_muldiv.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// alu_muldiv: execute-stage ALU with single-cycle ops plus an
// iterative shift-add multiplier / restoring divider (1 bit/clock).
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [3:0]       ALU_Operation_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] ALU_Result_o,
  output logic             Zero_o
);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_LUI   = 4'b0010;
  localparam logic [3:0] OP_AND   = 4'b0011;
  localparam logic [3:0] OP_OR    = 4'b0100;
  localparam logic [3:0] OP_XOR   = 4'b0101;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_MULH  = 4'b1001;
  localparam logic [3:0] OP_MULHU = 4'b1010;
  localparam logic [3:0] OP_RSVD  = 4'b1011;
  localparam logic [3:0] OP_DIV   = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;
  localparam logic [3:0] OP_REM   = 4'b1110;
  localparam logic [3:0] OP_REMU  = 4'b1111;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_FIN, S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_op;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_hi;
  logic [WIDTH-1:0]  r_lo;
  logic              r_neg_a;
  logic              r_neg_b;
  logic [WIDTH-1:0]  r_res;
  logic              r_zero;

  logic              w_iter;
  logic              w_sgn;
  logic [WIDTH-1:0]  w_mag_a;
  logic [WIDTH-1:0]  w_mag_b;
  logic [WIDTH-1:0]  w_single;
  logic [WIDTH:0]    w_sum;
  logic [WIDTH:0]    w_sh;
  logic              w_ge;
  logic [WIDTH-1:0]  w_diff;
  logic [WIDTH-1:0]  w_hi_n;
  logic [WIDTH-1:0]  w_lo_n;
  logic              w_bz;
  logic              w_ovf;
  logic [WIDTH-1:0]  w_mulh;
  logic [WIDTH-1:0]  w_quo_s;
  logic [WIDTH-1:0]  w_rem_s;
  logic [WIDTH-1:0]  w_fin;

  assign w_iter = ALU_Operation_i[3] && (ALU_Operation_i != OP_RSVD);
  assign w_sgn  = (ALU_Operation_i == OP_MULH) ||
                  (ALU_Operation_i == OP_DIV) ||
                  (ALU_Operation_i == OP_REM);
  assign w_mag_a = (w_sgn && A_i[WIDTH-1]) ? -A_i : A_i;
  assign w_mag_b = (w_sgn && B_i[WIDTH-1]) ? -B_i : B_i;

  // single-cycle result, decoded straight from the inputs
  always_comb begin
    w_single = '0;
    case (ALU_Operation_i)
      OP_ADD:  w_single = A_i + B_i;
      OP_SUB:  w_single = A_i - B_i;
      OP_LUI:  w_single = B_i;
      OP_AND:  w_single = A_i & B_i;
      OP_OR:   w_single = A_i | B_i;
      OP_XOR:  w_single = A_i ^ B_i;
      default: w_single = '0;
    endcase
  end

  // one engine step: shift-add for mul, restoring subtract for div
  always_comb begin
    w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_sh   = {r_hi, r_lo[WIDTH-1]};
    w_ge   = (w_sh >= {1'b0, r_b});
    w_diff = w_sh[WIDTH-1:0] - r_b;
    if (r_op[2]) begin
      w_hi_n = w_ge ? w_diff : w_sh[WIDTH-1:0];
      w_lo_n = {r_lo[WIDTH-2:0], w_ge};
    end else begin
      w_hi_n = w_sum[WIDTH:1];
      w_lo_n = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  // sign fixup and special-case substitution on the engine output
  always_comb begin
    w_bz    = (r_b == '0);
    w_ovf   = r_neg_a && (r_a == MIN_NEG) &&
              r_neg_b && (r_b == WIDTH'(1));
    w_mulh  = (r_neg_a ^ r_neg_b) ?
              (~r_hi + WIDTH'(r_lo == '0)) : r_hi;
    w_quo_s = (r_neg_a ^ r_neg_b) ? -r_lo : r_lo;
    w_rem_s = r_neg_a ? -r_hi : r_hi;
    w_fin   = '0;
    case (r_op)
      OP_MUL:   w_fin = r_lo;
      OP_MULH:  w_fin = w_mulh;
      OP_MULHU: w_fin = r_hi;
      OP_DIV:   w_fin = w_bz ? '1 : (w_ovf ? r_a : w_quo_s);
      OP_DIVU:  w_fin = w_bz ? '1 : r_lo;
      OP_REM:   w_fin = w_bz ? r_a : (w_ovf ? '0 : w_rem_s);
      OP_REMU:  w_fin = w_bz ? r_a : r_hi;
      default:  w_fin = '0;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start_i) w_next = w_iter ? S_RUN : S_DONE;
      S_RUN:  if (r_cnt == CNT_W'(1)) w_next = S_FIN;
      S_FIN:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // handshake outputs from state
  always_comb begin
    busy_o  = (r_state != S_IDLE);
    valid_o = (r_state == S_DONE);
  end

  // operand latch, engine iteration and result register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
      r_res   <= '0;
      r_zero  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: if (start_i) begin
          r_op    <= ALU_Operation_i;
          r_a     <= A_i;
          r_b     <= w_mag_b;
          r_hi    <= '0;
          r_lo    <= w_mag_a;
          r_neg_a <= w_sgn && A_i[WIDTH-1];
          r_neg_b <= w_sgn && B_i[WIDTH-1];
          r_cnt   <= w_iter ? CNT_W'(WIDTH) : '0;
          if (!w_iter) begin
            r_res  <= w_single;
            r_zero <= (w_single == '0);
          end
        end
        S_RUN: begin
          r_hi  <= w_hi_n;
          r_lo  <= w_lo_n;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        S_FIN: begin
          r_res  <= w_fin;
          r_zero <= (w_fin == '0);
        end
        default: ;
      endcase
    end
  end

  assign ALU_Result_o = r_res;
  assign Zero_o       = r_zero;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed + randomized checks of alu_muldiv
// against an arithmetic reference model.
module tb_alu_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_i;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy_o;
  logic         valid_o;
  logic [W-1:0] res;
  logic         zero;

  int checks = 0;
  int failures = 0;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .start_i(start_i),
    .ALU_Operation_i(op),
    .A_i(a),
    .B_i(b),
    .busy_o(busy_o),
    .valid_o(valid_o),
    .ALU_Result_o(res),
    .Zero_o(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_iter(input logic [3:0] o);
    return o[3] && (o != 4'hB);
  endfunction

  function automatic logic [W-1:0] model(input logic [3:0] o,
                                         input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    longint      sx;
    longint      sy;
    logic [63:0] p;
    logic [63:0] ux;
    logic [63:0] uy;
    logic        ovf;
    logic [W-1:0] r;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'b0, x};
    uy = {32'b0, y};
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    r = '0;
    case (o)
      4'h0: r = x + y;
      4'h1: r = x - y;
      4'h2: r = y;
      4'h3: r = x & y;
      4'h4: r = x | y;
      4'h5: r = x ^ y;
      4'h8: begin p = ux * uy; r = p[31:0]; end
      4'h9: begin p = sx * sy; r = p[63:32]; end
      4'hA: begin p = ux * uy; r = p[63:32]; end
      4'hC: r = (y == 0) ? '1 : (ovf ? x : W'(sx / sy));
      4'hD: r = (y == 0) ? '1 : x / y;
      4'hE: r = (y == 0) ? x : (ovf ? '0 : W'(sx % sy));
      4'hF: r = (y == 0) ? x : x % y;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic run(input logic [3:0] o, input logic [W-1:0] x,
                     input logic [W-1:0] y, input int poke,
                     input string tag);
    logic [W-1:0] exp;
    int lat;
    int cyc;
    bit seen;
    exp = model(o, x, y);
    lat = is_iter(o) ? W + 2 : 1;
    @(negedge clk);
    start_i = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start_i = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == poke) begin
        start_i = 1'b1; op = 4'h0; a = $urandom; b = $urandom;
      end else begin
        start_i = 1'b0;
      end
      if (valid_o) seen = 1'b1;
    end
    start_i = 1'b0;
    chk({tag, "_lat"}, W'(cyc), W'(lat));
    chk({tag, "_res"}, res, exp);
    chk({tag, "_zero"}, W'(zero), W'(exp == '0));
    chk({tag, "_busy"}, W'(busy_o), W'(1));
    @(negedge clk);
    chk({tag, "_pulse"}, W'(valid_o), W'(0));
    chk({tag, "_held"}, res, exp);
  endtask

  initial begin
    logic [3:0]   ro;
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    reset = 1'b0;
    start_i = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    #12;
    chk("rst_busy", W'(busy_o), W'(0));
    chk("rst_valid", W'(valid_o), W'(0));
    chk("rst_res", res, W'(0));
    chk("rst_zero", W'(zero), W'(1));
    @(negedge clk);
    reset = 1'b1;

    run(4'h0, 32'd5, 32'd7, 0, "add");
    run(4'h1, 32'd7, 32'd7, 0, "sub");
    run(4'h2, 32'h0, 32'h1234_5000, 0, "lui");
    run(4'h8, '1, '1, 0, "mul");
    run(4'h9, '1, '1, 0, "mulh");
    run(4'hA, '1, '1, 0, "mulhu");
    run(4'hC, -32'sd7, 32'd2, 0, "div");
    run(4'hE, -32'sd7, 32'd2, 0, "rem");
    run(4'hD, 32'd100, 32'd7, 0, "divu");
    run(4'hF, 32'd100, 32'd7, 0, "remu");
    run(4'hC, 32'h8000_0000, '1, 0, "div_ovf");
    run(4'hE, 32'h8000_0000, '1, 0, "rem_ovf");
    run(4'hD, 32'd9, 32'd0, 0, "divu_z");
    run(4'hF, 32'd9, 32'd0, 0, "remu_z");
    run(4'hC, -32'sd9, 32'd0, 0, "div_z");
    run(4'hE, -32'sd9, 32'd0, 0, "rem_z");
    run(4'h7, 32'd3, 32'd4, 0, "undef");
    run(4'hB, 32'd3, 32'd4, 0, "rsvd");

    run(4'hC, 32'd1000, 32'd3, 5, "ignore");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_res", res, 32'd333);
      chk("hold_valid", W'(valid_o), W'(0));
    end

    @(negedge clk);
    start_i = 1'b1; op = 4'h8; a = $urandom; b = $urandom;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", W'(busy_o), W'(0));
    chk("abort_valid", W'(valid_o), W'(0));
    chk("abort_res", res, W'(0));
    chk("abort_zero", W'(zero), W'(1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_novalid", W'(valid_o), W'(0));
    end
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("post_abort_valid", W'(valid_o), W'(0));
    end
    run(4'h8, 32'd3, 32'd4, 0, "mul3x4");

    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(0, 15));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = '0;
        1: ry = '1;
        2: rx = 32'h8000_0000;
        3: ry = 32'($urandom_range(1, 20));
        default: ;
      endcase
      run(ro, rx, ry, 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
